// File: rtl/pulse_counter.sv
// Free-running COUNT-bit up-counter emitting a one-cycle registered strobe on each
// all-ones -> zero wrap; serves as a tick/period generator and divider strobe source.
module pulse_counter #(
  parameter int unsigned COUNT = 4
) (
  input  logic clk,
  input  logic reset,
  output logic out_pulse
);

  localparam logic [COUNT-1:0] TERMINAL = '1;

  // Declaration initialisers give a defined start even if reset is never asserted.
  logic [COUNT-1:0] cnt     = '0;
  logic             pulse_q = 1'b0;

  logic [COUNT-1:0] cnt_d;
  logic             pulse_d;

  always_comb begin
    cnt_d   = cnt + 1'b1;
    pulse_d = (cnt == TERMINAL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt     <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign out_pulse = pulse_q;

endmodule

// File: tb/tb_pulse_counter.sv
// Directed self-checking bench for pulse_counter at COUNT = 4, 1 and 8.
module tb_pulse_counter;

  logic clk = 1'b0;
  logic rst4 = 1'b0;
  logic rst1 = 1'b0;
  logic rst8 = 1'b0;
  logic pulse4, pulse1, pulse8;

  int checks = 0;
  int errors = 0;

  always #1 clk = ~clk;

  pulse_counter #(.COUNT(4)) counter   (.clk(clk), .reset(rst4), .out_pulse(pulse4));
  pulse_counter #(.COUNT(1)) counter_1 (.clk(clk), .reset(rst1), .out_pulse(pulse1));
  pulse_counter #(.COUNT(8)) counter_8 (.clk(clk), .reset(rst8), .out_pulse(pulse8));

  task automatic test_power_up();
    logic [3:0] exp_cnt;
    logic       exp_pulse;
    #0.5;
    checks++;
    if (counter.cnt !== 4'd0 || pulse4 !== 1'b0) begin
      errors++;
      $display("FAIL power_up_init: cnt=%0h pulse=%0b, expected cnt=0 pulse=0", counter.cnt, pulse4);
    end
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      exp_cnt   = 4'(k % 16);
      exp_pulse = (k % 16 == 0);
      checks++;
      if (counter.cnt !== exp_cnt || pulse4 !== exp_pulse) begin
        errors++;
        $display("FAIL power_up_edge%0d: cnt=%0h pulse=%0b, expected cnt=%0h pulse=%0b",
                 k, counter.cnt, pulse4, exp_cnt, exp_pulse);
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_cnt;
    logic       exp_pulse;
    rst4 = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (counter.cnt !== 4'd0 || pulse4 !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: cnt=%0h pulse=%0b, expected cnt=0 pulse=0", counter.cnt, pulse4);
      end
    end
    rst4 = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      exp_cnt   = 4'(k % 16);
      exp_pulse = (k % 16 == 0);
      checks++;
      if (counter.cnt !== exp_cnt || pulse4 !== exp_pulse) begin
        errors++;
        $display("FAIL reset_release_edge%0d: cnt=%0h pulse=%0b, expected cnt=%0h pulse=%0b",
                 k, counter.cnt, pulse4, exp_cnt, exp_pulse);
      end
    end
  endtask

  task automatic test_reset_at_terminal();
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (counter.cnt !== 4'd15 || pulse4 !== 1'b0) begin
      errors++;
      $display("FAIL terminal_setup: cnt=%0h pulse=%0b, expected cnt=f pulse=0", counter.cnt, pulse4);
    end
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    checks++;
    if (counter.cnt !== 4'd0 || pulse4 !== 1'b0) begin
      errors++;
      $display("FAIL terminal_reset: cnt=%0h pulse=%0b, expected cnt=0 pulse=0", counter.cnt, pulse4);
    end
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      checks++;
      if (counter.cnt !== 4'(k) || pulse4 !== 1'b0) begin
        errors++;
        $display("FAIL terminal_resume%0d: cnt=%0h pulse=%0b, expected cnt=%0h pulse=0",
                 k, counter.cnt, pulse4, k);
      end
    end
  endtask

  task automatic test_reset_during_pulse();
    @(negedge clk);
    checks++;
    if (counter.cnt !== 4'd0 || pulse4 !== 1'b1) begin
      errors++;
      $display("FAIL pulse_setup: cnt=%0h pulse=%0b, expected cnt=0 pulse=1", counter.cnt, pulse4);
    end
    rst4 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (counter.cnt !== 4'd0 || pulse4 !== 1'b0) begin
        errors++;
        $display("FAIL pulse_reset%0d: cnt=%0h pulse=%0b, expected cnt=0 pulse=0", k, counter.cnt, pulse4);
      end
    end
    rst4 = 1'b0;
    @(negedge clk);
    checks++;
    if (counter.cnt !== 4'd1 || pulse4 !== 1'b0) begin
      errors++;
      $display("FAIL pulse_resume: cnt=%0h pulse=%0b, expected cnt=1 pulse=0", counter.cnt, pulse4);
    end
  endtask

  task automatic test_count1();
    logic exp_cnt;
    logic exp_pulse;
    rst1 = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (counter_1.cnt !== 1'b0 || pulse1 !== 1'b0) begin
      errors++;
      $display("FAIL count1_reset: cnt=%0h pulse=%0b, expected cnt=0 pulse=0", counter_1.cnt, pulse1);
    end
    rst1 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_cnt   = (k % 2 == 1);
      exp_pulse = (k % 2 == 0);
      checks++;
      if (counter_1.cnt !== exp_cnt || pulse1 !== exp_pulse) begin
        errors++;
        $display("FAIL count1_edge%0d: cnt=%0h pulse=%0b, expected cnt=%0h pulse=%0b",
                 k, counter_1.cnt, pulse1, exp_cnt, exp_pulse);
      end
    end
  endtask

  task automatic test_count8();
    logic [7:0] exp_cnt;
    logic       exp_pulse;
    int         n_pulses;
    int         last_pulse;
    n_pulses   = 0;
    last_pulse = 0;
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      exp_cnt   = 8'(k % 256);
      exp_pulse = (k % 256 == 0);
      checks++;
      if (counter_8.cnt !== exp_cnt || pulse8 !== exp_pulse) begin
        errors++;
        $display("FAIL count8_edge%0d: cnt=%0h pulse=%0b, expected cnt=%0h pulse=%0b",
                 k, counter_8.cnt, pulse8, exp_cnt, exp_pulse);
      end
      if (pulse8 === 1'b1) begin
        if (n_pulses > 0) begin
          checks++;
          if (k - last_pulse != 256) begin
            errors++;
            $display("FAIL count8_spacing: got %0d cycles, expected 256", k - last_pulse);
          end
        end
        n_pulses++;
        last_pulse = k;
      end
    end
    checks++;
    if (n_pulses != 2) begin
      errors++;
      $display("FAIL count8_npulses: got %0d, expected 2", n_pulses);
    end
  endtask

  initial begin
    test_power_up();
    test_reset();
    test_reset_at_terminal();
    test_reset_during_pulse();
    test_count1();
    test_count8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
